// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_BITS  = 32;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;
  localparam int LAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fsmState_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one synchronous registered read port.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic                 clk,
  input  logic                 wrEn,
  input  logic [IDX_W-1:0]     wrIdx,
  input  logic [WORD_BITS-1:0] wrData,
  input  logic                 rdEn,
  input  logic [IDX_W-1:0]     rdIdx,
  output logic [WORD_BITS-1:0] rdData
);

  logic [WORD_BITS-1:0] mem [DEPTH];

  // NOTE: storage and its read register carry no reset so the array maps onto RAM macros;
  // contents survive a responder reset by design.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrIdx] <= wrData;
    if (rdEn) rdData <= mem[rdIdx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, one outstanding request,
// configurable read latency, one response (data or ack + error) per request.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [7:0]        err_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]        ADDR_LIMIT = (ADDR_W + 1)'(WORD_BYTES * DEPTH);
  localparam logic [LAT_CNT_W-1:0]   LAT_LOAD   = LAT_CNT_W'(READ_LAT - 1);

  fsmState_t            state;
  logic [LAT_CNT_W-1:0] latCnt;
  logic                 rdOk;
  logic                 accept;
  logic                 addrErr;
  logic [IDX_W-1:0]     wordIdx;
  logic                 wrEn;
  logic                 rdEn;
  logic [31:0]          arrRdata;

  assign accept  = req_valid && req_ready;
  assign addrErr = (req_addr[BYTE_OFF_W-1:0] != '0) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign wordIdx = req_addr[BYTE_OFF_W +: IDX_W];
  assign wrEn    = accept && req_we && !addrErr;
  assign rdEn    = accept && !req_we && !addrErr;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrIdx  (wordIdx),
    .wrData (req_wdata),
    .rdEn   (rdEn),
    .rdIdx  (wordIdx),
    .rdData (arrRdata)
  );

  // The array read register holds the word captured at accept; rdOk exposes it only in RESP.
  assign rsp_rdata = rdOk ? arrRdata : '0;

  // latCnt counts down the remaining WAIT cycles; RESP is entered as it steps off 1,
  // so a read responds READ_LAT cycles after the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rdOk      <= 1'b0;
      latCnt    <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (addrErr) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (req_we) begin
              wr_count  <= wr_count + 16'd1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rd_count <= rd_count + 16'd1;
              if (READ_LAT <= 1) begin
                rdOk      <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end else begin
                latCnt <= LAT_LOAD;
                state  <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          latCnt <= latCnt - 1'b1;
          if (latCnt == LAT_CNT_W'(1)) begin
            rdOk      <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rdOk      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rdOk      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
